stm_gain_line_reader: RTL and testbench

Read-side sequencer for the Gain STM memory: 16-bit write port, 512-bit read port, 8 read lines per STM index. On a start request it fetches the 8 lines of one STM index and streams them out as one 16-bit transducer word per cycle, with no gaps, towards the drive/PWM pipeline. It prefetches the next line so the stream is contiguous, and it queues one further request while busy. The block runs entirely in the read-port clock domain.

---
 rtl/stm_gain_line_reader.sv | 128 ++++++++++++
 tb/tb_stm_gain_line_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stm_gain_line_reader.sv
// Gain STM read-side sequencer: fetches the 512-bit lines of one STM index and
// streams them out as one 16-bit transducer word per cycle, prefetching ahead.
module stm_gain_line_reader #(
   parameter int NUM_TRANS  = 249,
   parameter int IDX_WIDTH  = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [IDX_WIDTH-1:0] IDX,
   output logic                 BUSY,
   output logic [IDX_WIDTH+2:0] ADDR,
   input  logic [511:0]         DATA_IN,
   output logic                 DOUT_VALID,
   output logic [15:0]          DOUT,
   output logic [7:0]           DOUT_ADDR,
   output logic                 DONE
);

   localparam int          NLINES    = (NUM_TRANS + 31) / 32;
   localparam logic [7:0]  LAST_ADDR = 8'(NUM_TRANS - 1);
   localparam logic [2:0]  LAST_LINE = 3'(NLINES - 1);
   localparam logic [4:0]  PF_WORD   = 5'(31 - RD_LATENCY);
   localparam logic [4:0]  FILL_CAP  = 5'(RD_LATENCY - 1);
   localparam logic [4:0]  FILL_OUT  = 5'(RD_LATENCY);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;

   logic [1:0]           state;
   logic [4:0]           fcnt;
   logic [2:0]           line;
   logic [4:0]           word;
   logic [2:0]           nline;
   logic [4:0]           nword;
   logic                 is_last;
   logic [511:0]         line_p0;
   logic [IDX_WIDTH-1:0] seq_idx;
   logic                 pend;
   logic [IDX_WIDTH-1:0] pend_idx;

   function automatic logic [15:0] word_sel(input logic [511:0] l, input logic [4:0] w);
      return l[{w, 4'b0000} +: 16];
   endfunction

   assign {nline, nword} = {line, word} + 8'd1;
   assign is_last        = ({line, word} == LAST_ADDR);
   assign DOUT_ADDR      = {line, word};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         fcnt       <= '0;
         line       <= '0;
         word       <= '0;
         seq_idx    <= '0;
         pend       <= 1'b0;
         pend_idx   <= '0;
         BUSY       <= 1'b0;
         ADDR       <= '0;
         DOUT_VALID <= 1'b0;
         DOUT       <= '0;
         DONE       <= 1'b0;
      end else begin
         // A request arriving while busy is held one-deep; the newest index wins.
         if (START && state != S_IDLE) begin
            pend     <= 1'b1;
            pend_idx <= IDX;
         end
         case (state)
            S_IDLE: begin
               if (START) begin
                  ADDR    <= {IDX, 3'd0};
                  seq_idx <= IDX;
                  BUSY    <= 1'b1;
                  fcnt    <= '0;
                  state   <= S_FILL;
               end
            end
            S_FILL: begin
               fcnt <= fcnt + 5'd1;
               if (fcnt == FILL_CAP)
                  line_p0 <= DATA_IN;
               if (fcnt == FILL_OUT) begin
                  DOUT       <= line_p0[15:0];
                  line       <= '0;
                  word       <= '0;
                  DOUT_VALID <= 1'b1;
                  DONE       <= (LAST_ADDR == 8'd0);
                  state      <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (is_last) begin
                  DOUT_VALID <= 1'b0;
                  DONE       <= 1'b0;
                  if (START || pend) begin
                     ADDR    <= {(START ? IDX : pend_idx), 3'd0};
                     seq_idx <= START ? IDX : pend_idx;
                     pend    <= 1'b0;
                     fcnt    <= '0;
                     state   <= S_FILL;
                  end else begin
                     BUSY  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  line <= nline;
                  word <= nword;
                  DOUT <= word_sel(line_p0, nword);
                  DONE <= ({nline, nword} == LAST_ADDR);
                  // Issue the next line early enough that it lands as word 31 goes out.
                  if (line != LAST_LINE) begin
                     if (nword == 5'd31)
                        line_p0 <= DATA_IN;
                     if (nword == PF_WORD)
                        ADDR <= {seq_idx, line + 3'd1};
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stm_gain_line_reader.sv
// Bench for stm_gain_line_reader: default instance driven through directed runs,
// plus three parameter-sweep instances started together.
module tb_stm_gain_line_reader;

   localparam int IW = 10;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   logic       start0 = 1'b0, rst0 = 1'b1, start_s = 1'b0, rst_s = 1'b1;
   logic [9:0] idx0 = '0, idx_s = '0;
   int         exp_idx0 = 0;
   int         t0 = 0;
   int         dc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Memory content: word t of index ix
   function automatic logic [15:0] mword(input logic [9:0] ix, input logic [7:0] t);
      return {t, ~t ^ ix[7:0] ^ 8'h05};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   for (genvar g = 0; g < 4; g++) begin : gi
      localparam int NT = (g == 0) ? 249 : (g == 1) ? 32 : 256;
      localparam int LT = (g == 2) ? 1 : (g == 3) ? 30 : 2;
      localparam int NL = (NT + 31) / 32;

      logic         start, rst, busy, dv, done;
      logic [9:0]   idx;
      logic [12:0]  addr;
      logic [511:0] din;
      logic [15:0]  dout;
      logic [7:0]   da;
      logic [12:0]  hist [0:31];
      logic [12:0]  raddr;
      int runs = 0, first_c = 0, done_c = 0;

      assign start = (g == 0) ? start0 : start_s;
      assign rst   = (g == 0) ? rst0 : rst_s;
      assign idx   = (g == 0) ? idx0 : idx_s;

      stm_gain_line_reader #(.NUM_TRANS(NT), .IDX_WIDTH(IW), .RD_LATENCY(LT)) dut (
         .CLK(CLK), .RST(rst), .START(start), .IDX(idx), .BUSY(busy), .ADDR(addr),
         .DATA_IN(din), .DOUT_VALID(dv), .DOUT(dout), .DOUT_ADDR(da), .DONE(done)
      );

      // Read port: data for an address registered at edge e is capturable at edge e+LT
      always @(posedge CLK) begin
         hist[0] <= addr;
         for (int i = 1; i < 32; i++) hist[i] <= hist[i-1];
      end
      assign raddr = (LT == 1) ? addr : hist[(LT >= 2) ? LT - 2 : 0];

      always_comb begin
         din = '0;
         for (int j = 0; j < 32; j++)
            din[16*j +: 16] = mword(raddr[12:3], {raddr[2:0], 5'(j)});
      end

      initial begin : mon
         int n;
         logic [9:0] ci;
         n  = 0;
         ci = '0;
         forever begin
            @(negedge CLK);
            if (!rst) begin
               check("rd_line_bound", addr[2:0] <= 3'(NL - 1), 1);
               if (dv) begin
                  if (n == 0) begin
                     ci      = (g == 0) ? 10'(exp_idx0) : 10'd4;
                     first_c = cyc;
                  end
                  check("dout_addr", da, n);
                  check("dout", dout, mword(ci, 8'(n)));
                  check("done_last", done, n == NT - 1);
                  if (n == NT - 1) begin
                     done_c = cyc;
                     runs++;
                     n = 0;
                  end else n++;
               end else begin
                  if (n != 0) check("contig", dv, 1);
                  check("done_idle", done, 0);
               end
            end
            if (rst) n = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst0  = 1'b0;
      rst_s = 1'b0;
      check("rst_busy", gi[0].busy, 0);
      check("rst_addr", gi[0].addr, 0);
      check("rst_vld", gi[0].dv, 0);
      check("rst_dout", gi[0].dout, 0);
      check("rst_daddr", gi[0].da, 0);
      check("rst_done", gi[0].done, 0);

      // Basic run, index 5, with the sweep instances started on the same edge
      exp_idx0 = 5; idx0 = 10'd5; start0 = 1'b1;
      idx_s = 10'd4; start_s = 1'b1;
      tick();
      start0 = 1'b0; start_s = 1'b0;
      t0 = cyc;
      check("addr_e0", gi[0].addr, 13'h028);
      for (int c = 0; c <= 260; c++) begin
         int ln;
         if (c > 0) tick();
         ln = (c / 32 > 7) ? 7 : c / 32;
         check("b_vld", gi[0].dv, c >= 3 && c <= 251);
         check("b_done", gi[0].done, c == 251);
         check("b_busy", gi[0].busy, c <= 251);
         check("b_addr", gi[0].addr, {10'd5, 3'(ln)});
      end
      repeat (40) tick();
      check("b_runs", gi[0].runs, 1);
      check("b_first", gi[0].first_c - t0, 3);
      check("b_last", gi[0].done_c - t0, 251);
      check("sw32_runs", gi[1].runs, 1);
      check("sw32_first", gi[1].first_c - t0, 3);
      check("sw32_last", gi[1].done_c - t0, 34);
      check("sw32_addr", gi[1].addr, {10'd4, 3'd0});
      check("sw256l1_runs", gi[2].runs, 1);
      check("sw256l1_first", gi[2].first_c - t0, 2);
      check("sw256l1_last", gi[2].done_c - t0, 257);
      check("sw256l1_word", gi[2].dout, mword(10'd4, 8'd255));
      check("sw256l30_runs", gi[3].runs, 1);
      check("sw256l30_first", gi[3].first_c - t0, 31);
      check("sw256l30_last", gi[3].done_c - t0, 286);
      check("sw256l30_word", gi[3].dout, mword(10'd4, 8'd255));
      check("sw256l30_daddr", gi[3].da, 255);

      // Queued start: 3, then 7 at edge 50 and 9 at edge 60; only 9 follows
      exp_idx0 = 3; idx0 = 10'd3; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      dc = -1;
      for (int c = 1; c <= 560; c++) begin
         tick();
         if (c == 49) begin start0 = 1'b1; idx0 = 10'd7; end
         if (c == 50) start0 = 1'b0;
         if (c == 59) begin start0 = 1'b1; idx0 = 10'd9; end
         if (c == 60) start0 = 1'b0;
         if (dc < 0 && gi[0].done) begin dc = c; exp_idx0 = 9; end
         if (c == 252) check("q_addr", gi[0].addr, 13'h048);
         check("q_vld", gi[0].dv, (c >= 3 && c <= 251) || (c >= 255 && c <= 503));
         check("q_busy", gi[0].busy, c <= 503);
      end
      check("q_done_cyc", dc, 251);
      check("q_runs", gi[0].runs, 3);

      // START in the DONE cycle is taken as the next request
      exp_idx0 = 5; idx0 = 10'd5; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 560; c++) begin
         tick();
         if (c == 251) begin start0 = 1'b1; idx0 = 10'd12; end
         if (c == 252) begin start0 = 1'b0; exp_idx0 = 12; end
         if (c == 252) check("bd_addr", gi[0].addr, 13'h060);
         check("bd_vld", gi[0].dv, (c >= 3 && c <= 251) || (c >= 255 && c <= 503));
         check("bd_done", gi[0].done, c == 251 || c == 503);
         check("bd_busy", gi[0].busy, c <= 503);
      end
      check("bd_runs", gi[0].runs, 5);

      // Reset at DOUT_ADDR=100 with a request pending
      exp_idx0 = 5; idx0 = 10'd5; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 140; c++) begin
         tick();
         if (c == 19) begin start0 = 1'b1; idx0 = 10'd7; end
         if (c == 20) start0 = 1'b0;
         if (c == 103) begin
            check("r_daddr_pre", gi[0].da, 100);
            rst0 = 1'b1;
         end
         if (c == 104) begin
            rst0 = 1'b0;
            check("r_busy", gi[0].busy, 0);
            check("r_addr", gi[0].addr, 0);
            check("r_vld", gi[0].dv, 0);
            check("r_dout", gi[0].dout, 0);
            check("r_daddr", gi[0].da, 0);
            check("r_done", gi[0].done, 0);
         end
         if (c > 104) begin
            check("r_idle_vld", gi[0].dv, 0);
            check("r_idle_busy", gi[0].busy, 0);
         end
      end
      exp_idx0 = 2; idx0 = 10'd2; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 260; c++) begin
         tick();
         check("ra_vld", gi[0].dv, c >= 3 && c <= 251);
         check("ra_done", gi[0].done, c == 251);
      end
      check("ra_runs", gi[0].runs, 6);
      check("ra_daddr", gi[0].da, 248);
      check("ra_dout", gi[0].dout, mword(10'd2, 8'd248));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
